// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer
//   Sits between the UART receiver and the H-bridge PWM stage. It decodes command bytes into
//   per-motor enable/direction. Before any direction reversal it forces both enables off for
//   DEAD_CYC cycles, so a bridge never changes direction while it is being driven.
//
// Optional feature: define MOTOR_WDT_EN to build the watchdog. The watchdog stops both motors
//   when RUN sees no move command for WDT_CYC cycles. Without the macro, wdt_trip is tied to 0.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-high reset
//   rx_data   in   [7:0] received command byte
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   EN1/EN2   out  motor 1/2 PWM enable (registered)
//   DIR1/DIR2 out  motor 1/2 direction, 1 = forward (registered)
//   busy      out  high while in DEAD or ARM
//   wdt_trip  out  one-cycle pulse when the watchdog stops the motors
//   state     out  [1:0] 0 IDLE, 1 RUN, 2 DEAD, 3 ARM
module motor_cmd_sequencer #(
    parameter int unsigned DEAD_CYC = 5000,
    parameter int unsigned WDT_CYC  = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       EN1,
    output logic       EN2,
    output logic       DIR1,
    output logic       DIR2,
    output logic       busy,
    output logic       wdt_trip,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDead = 2'd2,
        StArm  = 2'd3
    } state_e;

    localparam logic [24:0] DEAD_LAST = 25'(DEAD_CYC - 1);
    localparam logic [24:0] CNT_MAX   = '1;

    state_e      st_q, st_d;
    logic [1:0]  en_q, en_d;       // {EN1, EN2}
    logic [1:0]  dir_q, dir_d;     // {DIR1, DIR2}
    logic [1:0]  tgt_en_q, tgt_en_d;
    logic [1:0]  tgt_dir_q, tgt_dir_d;
    logic [24:0] dead_cnt_q, dead_cnt_d;

    // A command that lands on the DEAD expiry cycle is held one cycle and replayed in ARM.
    logic        def_move_q, def_move_d;
    logic        def_stop_q, def_stop_d;
    logic [1:0]  def_en_q, def_en_d;
    logic [1:0]  def_dir_q, def_dir_d;

    logic        rx_move, rx_stop;
    logic [1:0]  rx_en, rx_dir;
    logic        act_move, act_stop;
    logic [1:0]  act_en, act_dir;
    logic        wdt_expire;

    // Command decode
    always_comb begin
        rx_move = 1'b0;
        rx_stop = 1'b0;
        rx_en   = 2'b00;
        rx_dir  = 2'b11;
        if (rx_valid) begin
            case (rx_data)
                8'h66: begin rx_move = 1'b1; rx_en = 2'b11; rx_dir = 2'b11; end
                8'h62: begin rx_move = 1'b1; rx_en = 2'b11; rx_dir = 2'b00; end
                8'h72: begin rx_move = 1'b1; rx_en = 2'b10; rx_dir = 2'b11; end
                8'h6C: begin rx_move = 1'b1; rx_en = 2'b01; rx_dir = 2'b11; end
                8'h73: rx_stop = 1'b1;
                default: ;
            endcase
        end
    end

    // A live command takes priority over a deferred one (the deferred one only exists in ARM).
    always_comb begin
        if (rx_move || rx_stop) begin
            act_move = rx_move;
            act_stop = rx_stop;
            act_en   = rx_en;
            act_dir  = rx_dir;
        end else begin
            act_move = def_move_q;
            act_stop = def_stop_q;
            act_en   = def_en_q;
            act_dir  = def_dir_q;
        end
    end

    // Next-state logic
    always_comb begin
        st_d       = st_q;
        en_d       = en_q;
        dir_d      = dir_q;
        tgt_en_d   = tgt_en_q;
        tgt_dir_d  = tgt_dir_q;
        dead_cnt_d = dead_cnt_q;
        def_move_d = 1'b0;
        def_stop_d = 1'b0;
        def_en_d   = 2'b00;
        def_dir_d  = 2'b11;

        unique case (st_q)
            StIdle: begin
                if (act_move) begin
                    tgt_en_d  = act_en;
                    tgt_dir_d = act_dir;
                    if (act_dir == dir_q) begin
                        st_d = StRun;
                        en_d = act_en;
                    end else begin
                        st_d       = StDead;
                        dead_cnt_d = '0;
                    end
                end
            end
            StRun: begin
                if (act_move) begin
                    tgt_en_d  = act_en;
                    tgt_dir_d = act_dir;
                    if (act_dir == dir_q) begin
                        en_d = act_en;
                    end else begin
                        en_d       = 2'b00;
                        st_d       = StDead;
                        dead_cnt_d = '0;
                    end
                end else if (act_stop) begin
                    en_d = 2'b00;
                    st_d = StIdle;
                end else if (wdt_expire) begin
                    en_d = 2'b00;
                    st_d = StIdle;
                end
            end
            StDead: begin
                if (dead_cnt_q >= DEAD_LAST) begin
                    st_d       = StArm;
                    dir_d      = tgt_dir_q;
                    def_move_d = act_move;
                    def_stop_d = act_stop;
                    def_en_d   = act_en;
                    def_dir_d  = act_dir;
                end else if (act_stop) begin
                    st_d = StIdle;
                end else if (act_move && (act_dir == dir_q)) begin
                    // Back to the direction still applied: no dead-time needed.
                    tgt_en_d  = act_en;
                    tgt_dir_d = act_dir;
                    st_d      = StRun;
                    en_d      = act_en;
                end else begin
                    if (act_move) begin
                        tgt_en_d  = act_en;
                        tgt_dir_d = act_dir;
                    end
                    if (dead_cnt_q != CNT_MAX) begin
                        dead_cnt_d = dead_cnt_q + 25'd1;
                    end
                end
            end
            StArm: begin
                if (act_stop) begin
                    st_d = StIdle;
                end else if (act_move) begin
                    tgt_en_d  = act_en;
                    tgt_dir_d = act_dir;
                    if (act_dir == dir_q) begin
                        st_d = StRun;
                        en_d = act_en;
                    end else begin
                        st_d       = StDead;
                        dead_cnt_d = '0;
                    end
                end else begin
                    st_d = StRun;
                    en_d = tgt_en_q;
                end
            end
            default: st_d = StIdle;
        endcase
    end

`ifdef MOTOR_WDT_EN
    localparam logic [24:0] WDT_LAST = 25'(WDT_CYC - 1);

    logic [24:0] wdt_cnt_q, wdt_cnt_d;
    logic        trip_q, trip_d;

    assign wdt_expire = (st_q == StRun) && (wdt_cnt_q >= WDT_LAST);

    // Counts only while staying in RUN without a move; any move or entry into RUN clears it.
    always_comb begin
        wdt_cnt_d = '0;
        if ((st_q == StRun) && (st_d == StRun) && !act_move && (wdt_cnt_q != CNT_MAX)) begin
            wdt_cnt_d = wdt_cnt_q + 25'd1;
        end
        trip_d = wdt_expire && !act_move && !act_stop;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdt_cnt_q <= '0;
            trip_q    <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            trip_q    <= trip_d;
        end
    end

    assign wdt_trip = trip_q;
`else
    assign wdt_expire = 1'b0;
    assign wdt_trip   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q       <= StIdle;
            en_q       <= 2'b00;
            dir_q      <= 2'b11;
            tgt_en_q   <= 2'b00;
            tgt_dir_q  <= 2'b11;
            dead_cnt_q <= '0;
            def_move_q <= 1'b0;
            def_stop_q <= 1'b0;
            def_en_q   <= 2'b00;
            def_dir_q  <= 2'b11;
        end else begin
            st_q       <= st_d;
            en_q       <= en_d;
            dir_q      <= dir_d;
            tgt_en_q   <= tgt_en_d;
            tgt_dir_q  <= tgt_dir_d;
            dead_cnt_q <= dead_cnt_d;
            def_move_q <= def_move_d;
            def_stop_q <= def_stop_d;
            def_en_q   <= def_en_d;
            def_dir_q  <= def_dir_d;
        end
    end

    assign EN1   = en_q[1];
    assign EN2   = en_q[0];
    assign DIR1  = dir_q[1];
    assign DIR2  = dir_q[0];
    assign state = st_q;
    assign busy  = (st_q == StDead) || (st_q == StArm);

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
module tb_motor_cmd_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       EN1, EN2, DIR1, DIR2, busy, wdt_trip;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int trip_seen = 0;

    motor_cmd_sequencer #(
        .DEAD_CYC(4),
        .WDT_CYC (20)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .EN1     (EN1),
        .EN2     (EN2),
        .DIR1    (DIR1),
        .DIR2    (DIR2),
        .busy    (busy),
        .wdt_trip(wdt_trip),
        .state   (state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Busy follows from the expected state: DEAD (2) and ARM (3).
    task automatic chk_out(input string tag, input logic [1:0] en, input logic [1:0] dir,
                           input logic [1:0] st);
        chk($sformatf("%s.en", tag), {30'd0, EN1, EN2}, {30'd0, en});
        chk($sformatf("%s.dir", tag), {30'd0, DIR1, DIR2}, {30'd0, dir});
        chk($sformatf("%s.state", tag), {30'd0, state}, {30'd0, st});
        chk($sformatf("%s.busy", tag), {31'd0, busy}, {31'd0, st[1]});
    endtask

    // Advance one clock and observe just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (wdt_trip === 1'b1) trip_seen++;
    endtask

    // Byte is valid for one cycle; on return the outputs show the cycle after it.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        // Reset
        #1 RST = 1'b1;
        #1;
        chk_out("rst", 2'b00, 2'b11, 2'd0);
        chk("rst.trip", {31'd0, wdt_trip}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        tick();
        chk_out("post_rst", 2'b00, 2'b11, 2'd0);

        // Forward from IDLE: same direction, no dead-time
        send(8'h66);
        chk_out("fwd", 2'b11, 2'b11, 2'd1);

        // Right, left, then an unknown byte
        send(8'h72);
        chk_out("right", 2'b10, 2'b11, 2'd1);
        send(8'h6C);
        chk_out("left", 2'b01, 2'b11, 2'd1);
        tick();
        send(8'h41);
        chk_out("ignored", 2'b01, 2'b11, 2'd1);
        send(8'h66);
        chk_out("fwd2", 2'b11, 2'b11, 2'd1);

        // Reversal to back: EN off, DIR changes after 4 cycles, ARM, then RUN
        send(8'h62);
        chk_out("rev_dead0", 2'b00, 2'b11, 2'd2);
        tick();
        tick();
        tick();
        chk_out("rev_dead3", 2'b00, 2'b11, 2'd2);
        tick();
        chk_out("rev_arm", 2'b00, 2'b00, 2'd3);
        tick();
        chk_out("rev_run", 2'b11, 2'b00, 2'd1);

        // Stop during DEAD keeps the old DIR; same-dir move then runs at once
        send(8'h66);
        chk_out("stop_dead", 2'b00, 2'b00, 2'd2);
        tick();
        send(8'h73);
        chk_out("stop_idle", 2'b00, 2'b00, 2'd0);
        tick();
        chk_out("stop_hold", 2'b00, 2'b00, 2'd0);
        send(8'h62);
        chk_out("idle_same", 2'b11, 2'b00, 2'd1);

        // Abort DEAD by commanding the original direction
        send(8'h66);
        chk_out("abort_dead", 2'b00, 2'b00, 2'd2);
        tick();
        send(8'h62);
        chk_out("abort_run", 2'b11, 2'b00, 2'd1);

        // Command on the DEAD expiry cycle is evaluated in ARM: it reverses again
        send(8'h66);
        tick();
        tick();
        tick();
        chk_out("exp_last_dead", 2'b00, 2'b00, 2'd2);
        send(8'h62);
        chk_out("exp_arm", 2'b00, 2'b11, 2'd3);
        tick();
        chk_out("exp_redead", 2'b00, 2'b11, 2'd2);
        tick();
        tick();
        tick();
        chk_out("exp_redead3", 2'b00, 2'b11, 2'd2);
        tick();
        chk_out("exp_arm2", 2'b00, 2'b00, 2'd3);
        tick();
        chk_out("exp_run", 2'b11, 2'b00, 2'd1);

`ifdef MOTOR_WDT_EN
        // Silence: trip 20 cycles after the command takes effect
        send(8'h62);
        trip_seen = 0;
        repeat (19) tick();
        chk_out("wdt_pre", 2'b11, 2'b00, 2'd1);
        chk("wdt_pre.seen", trip_seen, 32'd0);
        tick();
        chk_out("wdt_trip", 2'b00, 2'b00, 2'd0);
        chk("wdt_trip.pulse", {31'd0, wdt_trip}, 32'd1);
        tick();
        chk("wdt_trip.end", {31'd0, wdt_trip}, 32'd0);

        // Keep-alive every 15 cycles never trips
        send(8'h62);
        trip_seen = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (14) tick();
            send(8'h62);
        end
        chk_out("wdt_alive", 2'b11, 2'b00, 2'd1);
        chk("wdt_alive.seen", trip_seen, 32'd0);
`else
        send(8'h62);
        trip_seen = 0;
        repeat (1000) tick();
        chk_out("no_wdt", 2'b11, 2'b00, 2'd1);
        chk("no_wdt.seen", trip_seen, 32'd0);
`endif

        // Asynchronous reset mid-DEAD takes effect before the next edge
        send(8'h66);
        tick();
        chk_out("pre_rst_dead", 2'b00, 2'b00, 2'd2);
        RST = 1'b1;
        #1;
        chk_out("async_rst", 2'b00, 2'b11, 2'd0);
        chk("async_rst.trip", {31'd0, wdt_trip}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk_out("after_rst", 2'b00, 2'b11, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Command sequencer between the UART receiver and the motor PWM/driver stage.
- Decodes received command bytes into per-motor enable and direction.
- Enforces a dead-time with both enables off before any direction reversal, so the H-bridges never flip direction while driven.
- Optional watchdog stops both motors if the command stream goes silent.

Parameters:
- DEAD_CYC, 5000: cycles both enables are held off before a direction change (1 to 2^25-1).
- WDT_CYC, 25000000: watchdog timeout in cycles without a valid move command while running (1 to 2^25-1).

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RST  input  1  asynchronous, active-high reset.
- rx_data  input  8  received command byte; qualified by rx_valid.
- rx_valid  input  1  one-cycle strobe: rx_data is valid this cycle.
- EN1  output  1  motor 1 PWM enable, registered.
- EN2  output  1  motor 2 PWM enable, registered.
- DIR1  output  1  motor 1 direction (1 = forward), registered.
- DIR2  output  1  motor 2 direction (1 = forward), registered.
- busy  output  1  high while in DEAD or ARM.
- wdt_trip  output  1  one-cycle pulse when the watchdog stops the motors.
- state  output  2  current state: 0 IDLE, 1 RUN, 2 DEAD, 3 ARM.

Behaviour:
- Reset (asynchronous, any state): EN1=EN2=0, DIR1=DIR2=1, state=IDLE, busy=0, wdt_trip=0, counters=0, pending target cleared.
- Decode, sampled only when rx_valid=1:
  - 0x66 forward: EN=11, DIR=11.
  - 0x62 back: EN=11, DIR=00.
  - 0x72 right: EN=10, DIR=11.
  - 0x6C left: EN=01, DIR=11.
  - 0x73 stop.
  - Any other byte is ignored: no state change, watchdog not reloaded.
- A move command is "same-dir" if its DIR equals the current DIR outputs; otherwise it is "reversing".
- IDLE (EN=00):
  - Same-dir move: go to RUN; EN=target on cycle N+1.
  - Reversing move: latch target, go to DEAD.
  - Stop: no effect.
- RUN:
  - Same-dir move: EN=target at N+1; reload watchdog.
  - Reversing move: EN=00 at N+1; latch target; go to DEAD.
  - Stop: EN=00 at N+1; go to IDLE; DIR held.
- DEAD (EN=00, DIR=old):
  - Counter runs DEAD_CYC cycles, then DIR=target DIR and go to ARM.
- ARM (one cycle; EN=00, DIR=new): go to RUN; EN=target on the next cycle; watchdog reloaded.
- Reversal timing, command at cycle N: EN=00 at N+1, DIR new at N+1+DEAD_CYC, EN=target at N+2+DEAD_CYC.
- Commands during DEAD or ARM:
  - Move: overwrites the pending target (last wins).
  - In DEAD, if the new target DIR equals the old DIR: abort to RUN; EN=target next cycle.
  - In ARM, a move whose DIR differs from the new DIR re-enters DEAD with the counter restarted.
  - Stop: go to IDLE next cycle; EN stays 00; DIR keeps whatever value it had.
- Simultaneous events: a command arriving on the same cycle the DEAD counter expires is applied after the transition to ARM, i.e. it is evaluated in ARM on the following cycle.
- Counters are 25-bit and saturate at terminal count; they never wrap.

Optional Feature:
- Macro: MOTOR_WDT_EN.
- Defined:
  - In RUN, a 25-bit counter increments each cycle and is cleared by each accepted move command.
  - On reaching WDT_CYC-1 with no command: EN=00 next cycle, go to IDLE, wdt_trip pulses one cycle.
  - A move command arriving on the expiry cycle wins: no trip.
- Undefined: no watchdog logic; wdt_trip tied to 0; RUN persists until stop or reversal.

Test Plan (DEAD_CYC=4, WDT_CYC=20):
- Reset, then rx 0x66 at cycle 10 -> EN=11, DIR=11 at cycle 11; state=RUN; busy=0.
- In RUN forward, rx 0x62 at cycle 20 -> EN=00 at 21; DIR=00 at 25; state=ARM at 25; EN=11 at 26; busy=1 during 21-25.
- In RUN, rx 0x72 then 0x6C then 0x41 -> EN=10, then EN=01, then unchanged (0x41 ignored); DIR=11 throughout.
- During DEAD, rx 0x73 -> state=IDLE next cycle; EN=00; no DIR change; later 0x66 goes straight to RUN with no dead-time if DIR unchanged.
- With MOTOR_WDT_EN defined: rx 0x66 then silence -> EN=00 and wdt_trip=1 exactly 20 cycles after the command's effect; a 0x66 every 15 cycles -> no trip. Without the macro -> no trip after 1000 cycles.
- Assert RST mid-DEAD -> all outputs return to reset values immediately (before the next clock edge); state=IDLE.
